alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning ALU register-to-result latency in cycles (fixed to 1 in this revision).
REQ-002 SHALL have ports, clock and reset first: clock in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have req0_valid in 1, req0_ready out 1, req0_op in 4, req0_a in 8, req0_b in 8: requester 0 command channel.
REQ-004 SHALL have req1_valid in 1, req1_ready out 1, req1_op in 4, req1_a in 8, req1_b in 8: requester 1 command channel.
REQ-005 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_id out 1, rsp_result out 8, rsp_zero out 1, rsp_carry out 1, rsp_err out 1: response channel.
REQ-006 SHALL have alu_op out 4, alu_a out 8, alu_b out 8, alu_out out 1 (ALU output enable), alu_result in 8: ALU drive/return.
REQ-007 SHALL have busy out 1 (state != IDLE) and err_count out 8 (saturating error counter).

Function
REQ-008 Op encoding SHALL be ADD=0, SUB=1, MUL=2, DIV=3, SHL=4, SHR=5, ROL=6, ROR=7, AND=8, OR=9, XOR=10, NOT=11; 12-15 illegal.
REQ-009 FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; no other reachable states.
REQ-010 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; never both 1 in the same cycle.
REQ-011 Arbitration SHALL be round-robin: one valid requester wins; both valid -> the one not served last; after reset requester 0 wins first.
REQ-012 reqN_ready SHALL not depend combinationally on reqN_valid of the same requester; no path from rsp_ready to reqN_ready.
REQ-013 On accept (valid&&ready, cycle C0) op/a/b/id SHALL be latched; next state ISSUE unless op illegal or (DIV and b==0), then RESP directly.
REQ-014 ISSUE (C1): alu_op/alu_a/alu_b SHALL present latched values, alu_out=0; next state CAPTURE.
REQ-015 CAPTURE (C2): alu_op/a/b held, alu_out=1, alu_result sampled at end of C2; next state RESP.
REQ-016 Outside ISSUE/CAPTURE alu_op SHALL be 0, alu_a/alu_b 0x00, alu_out 0.
REQ-017 RESP: rsp_valid=1 and rsp_* stable until rsp_ready=1; on rsp_valid&&rsp_ready go to IDLE; new accept no earlier than next cycle.
REQ-018 Normal latency SHALL be accept at C0 -> rsp_valid asserted in C3; error latency accept at C0 -> rsp_valid in C1.
REQ-019 rsp_result SHALL be captured ALU value (8-bit, wraps mod 256); on error rsp_result=0xFF, rsp_err=1.
REQ-020 rsp_zero SHALL be 1 iff rsp_result==0x00 and rsp_err==0.
REQ-021 rsp_carry SHALL be computed internally: ADD -> bit 8 of 9-bit a+b; SUB -> 1 iff a<b (borrow); all other ops and errors -> 0.
REQ-022 rsp_id SHALL equal index of the requester whose command produced the response.
REQ-023 err_count SHALL increment by 1 on each error response handshake, saturating at 0xFF.
REQ-024 Requests arriving while busy SHALL be held by the requester (ready=0); none dropped or reordered within a requester.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, all outputs 0 (rsp_*, alu_*, reqN_ready, busy, err_count), round-robin pointer to favour requester 0.
REQ-026 Reset mid-operation SHALL discard the in-flight command with no response; first cycle after release SHALL behave as post-reset IDLE.

Verification
REQ-027 req0 ADD a=0xF0 b=0x20, rsp_ready=1 -> rsp_valid in C3, result 0x10, carry 1, zero 0, id 0, err 0.
REQ-028 req0 and req1 valid continuously with SUB 0x05-0x05 -> grants alternate 0,1,0,1; each rsp result 0x00, zero 1, carry 0.
REQ-029 req1 DIV a=0x10 b=0x00 -> rsp_valid in C1, result 0xFF, err 1, alu_out never asserted; err_count 0->1.
REQ-030 req0 op=0xE -> err 1 in C1; 256 consecutive illegal ops -> err_count saturates at 0xFF.
REQ-031 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready=0, busy=1 throughout; accept resumes cycle after handshake.
REQ-032 reset_n pulsed low during CAPTURE -> immediate IDLE, no rsp_valid, alu_out=0, next winner requester 0.

Source files
------------

// File: rtl/alu_ctrl.sv
// ALU command controller: two requester channels share one external ALU.
// A round-robin arbiter picks a command. The FSM drives the ALU, captures the
// returned value and carry, and then holds a response until it is accepted.
// Illegal opcodes and divide-by-zero skip the ALU and respond with an error.
module alu_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_out,
    input  logic [7:0] alu_result,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd11;

    // Index of the last CAPTURE cycle. The ALU result is sampled in that cycle.
    localparam logic [7:0] LAT_LAST = (ALU_LAT > 1) ? 8'(ALU_LAT - 1) : 8'd0;

    // A command is answered with an error when the opcode is outside the
    // defined set, or when it is a divide with a zero divisor.
    function automatic logic cmd_is_error(input logic [3:0] op, input logic [7:0] b);
        return (op > OP_NOT) || ((op == OP_DIV) && (b == 8'h00));
    endfunction

    // The carry comes from the operands and not from the ALU.
    // ADD uses the 9th sum bit. SUB uses the borrow.
    function automatic logic calc_carry(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (op == OP_ADD) begin
            return sum[8];
        end else if (op == OP_SUB) begin
            return (a < b);
        end else begin
            return 1'b0;
        end
    endfunction

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;               // requester favoured when both are valid
    logic       req0_ready_q, req0_ready_d;
    logic       req1_ready_q, req1_ready_d;
    logic       id_q, id_d;
    logic       carry_q, carry_d;
    logic [7:0] lat_cnt_q, lat_cnt_d;
    logic       busy_q, busy_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic       alu_out_q, alu_out_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] err_count_q, err_count_d;

    logic       acc0_s, acc1_s, accept_s, rsp_hs_s;
    logic       gnt0_s, gnt1_s;
    logic       cmd_id_s;
    logic [3:0] cmd_op_s;
    logic [7:0] cmd_a_s, cmd_b_s;

    // Handshake decode, command select and arbitration.
    // The ready flags are registered, so a grant never sees its own valid.
    always_comb begin
        acc0_s   = req0_valid && req0_ready_q;
        acc1_s   = req1_valid && req1_ready_q;
        accept_s = acc0_s || acc1_s;
        rsp_hs_s = rsp_valid_q && rsp_ready;
        cmd_id_s = acc1_s;
        cmd_op_s = acc1_s ? req1_op : req0_op;
        cmd_a_s  = acc1_s ? req1_a  : req0_a;
        cmd_b_s  = acc1_s ? req1_b  : req0_b;
        gnt0_s   = req0_valid && (!req1_valid || (ptr_q == 1'b0));
        gnt1_s   = req1_valid && (!req0_valid || (ptr_q == 1'b1));
    end

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        id_d         = id_q;
        carry_d      = carry_q;
        lat_cnt_d    = lat_cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_out_d    = alu_out_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    id_d    = cmd_id_s;
                    ptr_d   = ~cmd_id_s;
                    carry_d = calc_carry(cmd_op_s, cmd_a_s, cmd_b_s);
                    if (cmd_is_error(cmd_op_s, cmd_b_s)) begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = cmd_id_s;
                        rsp_result_d = 8'hFF;
                        rsp_zero_d   = 1'b0;
                        rsp_carry_d  = 1'b0;
                        rsp_err_d    = 1'b1;
                    end else begin
                        state_d  = ST_ISSUE;
                        alu_op_d = cmd_op_s;
                        alu_a_d  = cmd_a_s;
                        alu_b_d  = cmd_b_s;
                    end
                end else begin
                    req0_ready_d = gnt0_s;
                    req1_ready_d = gnt1_s;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_CAPTURE;
                alu_out_d = 1'b1;
                lat_cnt_d = 8'd0;
            end
            ST_CAPTURE: begin
                if (lat_cnt_q >= LAT_LAST) begin
                    state_d      = ST_RESP;
                    alu_op_d     = 4'd0;
                    alu_a_d      = 8'h00;
                    alu_b_d      = 8'h00;
                    alu_out_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = alu_result;
                    rsp_zero_d   = (alu_result == 8'h00);
                    rsp_carry_d  = carry_q;
                    rsp_err_d    = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d      = ST_IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_id_d     = 1'b0;
                    rsp_result_d = 8'h00;
                    rsp_zero_d   = 1'b0;
                    rsp_carry_d  = 1'b0;
                    rsp_err_d    = 1'b0;
                    req0_ready_d = gnt0_s;
                    req1_ready_d = gnt1_s;
                    if (rsp_err_q && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                alu_op_d    = 4'd0;
                alu_a_d     = 8'h00;
                alu_b_d     = 8'h00;
                alu_out_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset drops any in-flight command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            id_q         <= 1'b0;
            carry_q      <= 1'b0;
            lat_cnt_q    <= 8'd0;
            busy_q       <= 1'b0;
            alu_op_q     <= 4'd0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_out_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            id_q         <= id_d;
            carry_q      <= carry_d;
            lat_cnt_q    <= lat_cnt_d;
            busy_q       <= busy_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_out_q    <= alu_out_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_out    = alu_out_q;
    assign busy       = busy_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl. The bench models the external ALU.
// An expected response is queued when a command is accepted.
// The monitor compares each queued entry against the DUT response.
module tb_alu_ctrl;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd10;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_err;
    logic [7:0] rsp_result;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_out, busy;
    logic [7:0] err_count;

    typedef struct {
        logic       id;
        logic [7:0] result;
        logic       zero;
        logic       carry;
        logic       err;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    logic gnt_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   last_hs_cyc = 0;
    int   exp_err_cnt = 0;
    bit   rsp_seen = 1'b0;
    exp_t m_e;

    alu_ctrl #(.ALU_LAT(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_result(alu_result),
        .busy(busy), .err_count(err_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference ALU. The bench chooses shift amounts from b[2:0].
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [15:0] t;
        t = 16'h0000;
        case (op)
            4'd0:  t = {8'h00, a + b};
            4'd1:  t = {8'h00, a - b};
            4'd2:  t = {8'h00, a} * {8'h00, b};
            4'd3:  t = (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
            4'd4:  t = {8'h00, a << b[2:0]};
            4'd5:  t = {8'h00, a >> b[2:0]};
            4'd6:  begin t = {a, a} << b[2:0]; t = {8'h00, t[15:8]}; end
            4'd7:  t = {a, a} >> b[2:0];
            4'd8:  t = {8'h00, a & b};
            4'd9:  t = {8'h00, a | b};
            4'd10: t = {8'h00, a ^ b};
            4'd11: t = {8'h00, ~a};
            default: t = 16'h0000;
        endcase
        return t[7:0];
    endfunction

    // The ALU returns 0 unless alu_out is high. A capture in the wrong cycle therefore reads 0.
    always_comb alu_result = alu_out ? alu_fn(alu_op, alu_a, alu_b) : 8'h00;

    function automatic exp_t model(input logic id, input logic [3:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] s;
        e.id = id;
        e.acc_cyc = 0;
        s = {1'b0, a} + {1'b0, b};
        if ((op > 4'd11) || ((op == OP_DIV) && (b == 8'h00))) begin
            e.result = 8'hFF; e.err = 1'b1; e.zero = 1'b0; e.carry = 1'b0;
        end else begin
            e.result = alu_fn(op, a, b);
            e.err    = 1'b0;
            e.zero   = (e.result == 8'h00);
            e.carry  = (op == OP_ADD) ? s[8] : ((op == OP_SUB) ? (a < b) : 1'b0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one command and wait until it is accepted. The expected response is queued at the accept.
    task automatic send(input logic id, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        exp_t e;
        bit done;
        done = 1'b0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clock);
            if ((id == 1'b0 && req0_ready === 1'b1) || (id == 1'b1 && req1_ready === 1'b1)) begin
                e = model(id, op, a, b);
                e.acc_cyc = cyc;
                last_acc_cyc = cyc;
                sb.push_back(e);
                gnt_log.push_back(id);
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clock);
            ok = (sb.size() == 0) && !rsp_valid;
        end
        chk("drain", 32'(ok), 32'd1);
        @(posedge clock); #1;
    endtask

    // Monitor: checks the invariants and the scoreboard on every cycle.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            chk("rdy_excl", 32'(req0_ready & req1_ready), 32'd0);
            chk("rdy_busy", 32'(busy & (req0_ready | req1_ready)), 32'd0);
            chk("err_count", 32'(err_count), 32'(exp_err_cnt));
            if (!busy) chk("alu_idle", {11'd0, alu_op, alu_a, alu_b, alu_out}, 32'd0);
            if (alu_out) begin
                chk("alu_out_q", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("alu_out_err", 32'(sb[0].err), 32'd0);
            end
            if (rsp_valid) begin
                chk("rsp_q", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    m_e = sb[0];
                    if (!rsp_seen) begin
                        chk("latency", 32'(cyc - m_e.acc_cyc), m_e.err ? 32'd1 : 32'd3);
                        rsp_seen = 1'b1;
                    end
                    chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
                    chk("rsp_result", 32'(rsp_result), 32'(m_e.result));
                    chk("rsp_zero", 32'(rsp_zero), 32'(m_e.zero));
                    chk("rsp_carry", 32'(rsp_carry), 32'(m_e.carry));
                    chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                    chk("rsp_busy", 32'(busy), 32'd1);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        rsp_seen = 1'b0;
                        last_hs_cyc = cyc;
                        if (m_e.err && exp_err_cnt < 255) exp_err_cnt++;
                    end
                end
            end
        end
    end

    logic [3:0] t_op [13];
    logic [7:0] t_a  [13];
    logic [7:0] t_b  [13];
    bit         seen;

    initial begin
        t_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1};
        t_a  = '{8'h10, 8'h13, 8'h64, 8'h81, 8'h81, 8'h81, 8'h81, 8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h05};
        t_b  = '{8'h20, 8'h11, 8'h07, 8'h03, 8'h09, 8'h01, 8'h01, 8'h3C, 8'h30, 8'hFF, 8'h00, 8'h00, 8'h07};
        reset_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = 8'h00; req1_b = 8'h00;
        repeat (3) @(negedge clock);
        chk("reset_rsp", {20'd0, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry}, 32'd0);
        chk("reset_ctl", {9'd0, rsp_err, alu_op, alu_a, alu_b, alu_out}, 32'd0);
        chk("reset_misc", {21'd0, req0_ready, req1_ready, busy, err_count}, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // ADD with a carry out of bit 7.
        send(1'b0, OP_ADD, 8'hF0, 8'h20);
        drain();

        // A spread of legal operations from both requesters.
        for (int i = 0; i < 13; i++) send(1'(i % 2), t_op[i], t_a[i], t_b[i]);
        drain();

        // Illegal opcode from req0, then divide-by-zero from req1.
        send(1'b0, 4'hE, 8'h12, 8'h34);
        send(1'b1, OP_DIV, 8'h10, 8'h00);
        drain();

        // Both requesters stay valid: the grants alternate, starting with req0.
        gnt_log.delete();
        fork
            begin for (int i = 0; i < 4; i++) send(1'b0, OP_SUB, 8'h05, 8'h05); end
            begin for (int j = 0; j < 4; j++) send(1'b1, OP_SUB, 8'h05, 8'h05); end
        join
        drain();
        chk("rr_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < gnt_log.size(); i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));

        // The response is held for 5 cycles with rsp_ready low.
        // The waiting req1 command is accepted in the cycle after the handshake.
        rsp_ready = 1'b0;
        send(1'b0, OP_AND, 8'hF0, 8'h3C);
        gnt_log.delete();
        fork
            send(1'b1, OP_XOR, 8'hA5, 8'h0F);
        join_none
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = rsp_valid;
        end
        chk("hold_rsp_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clock);
        @(posedge clock); #1 rsp_ready = 1'b1;
        for (int k = 0; k < 20 && gnt_log.size() == 0; k++) @(negedge clock);
        chk("resume_acc", 32'(last_acc_cyc), 32'(last_hs_cyc + 1));
        drain();

        // Assert reset during CAPTURE. The command is dropped and req0 wins first afterwards.
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h02;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            if (req0_ready) begin
                m_e = model(1'b0, OP_ADD, 8'h01, 8'h02);
                m_e.acc_cyc = cyc;
                sb.push_back(m_e);
                seen = 1'b1;
            end
        end
        @(posedge clock); #1 req0_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            seen = alu_out;
        end
        chk("capture_seen", 32'(seen), 32'd1);
        #1 reset_n = 1'b0;
        sb.delete(); rsp_seen = 1'b0; exp_err_cnt = 0;
        #1;
        chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_mid_alu", 32'(alu_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        gnt_log.delete();
        fork
            send(1'b0, OP_ADD, 8'h03, 8'h04);
            send(1'b1, OP_ADD, 8'h05, 8'h06);
        join
        drain();
        chk("rst_first_win", 32'(gnt_log[0]), 32'd0);

        // Enough illegal commands to saturate the error counter.
        for (int i = 0; i < 260; i++) send(1'(i % 2), 4'(12 + (i % 4)), 8'(i), 8'h00);
        drain();
        chk("err_sat", 32'(err_count), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
